// File: rtl/conv_io_ctrl.sv
// conv_io_ctrl: host-facing buffer controller for a 1-D convolution engine.
// The host loads an X-word vector, start streams it to the engine over a
// valid/ready link, and the Y = X-F+1 results are collected into a result
// buffer that can be read at any time through rd_addr/rd_data.
// Optional feature: define CONV_IO_RELU_CHECK_EN to add the sticky relu_err
// output, flagging any negative result word accepted from the engine.
module conv_io_ctrl #(
    parameter int X = 32,
    parameter int F = 4,
    parameter int W = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [W-1:0]                ld_data,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic                        start,
    output logic [W-1:0]                x_data,
    output logic                        x_valid,
    input  logic                        x_ready,
    input  logic [W-1:0]                y_data,
    input  logic                        y_valid,
    output logic                        y_ready,
    input  logic [$clog2(X-F+1)-1:0]    rd_addr,
    output logic [W-1:0]                rd_data,
    output logic                        busy,
    output logic                        done
`ifdef CONV_IO_RELU_CHECK_EN
    ,
    output logic                        relu_err
`endif
);

    localparam int Y  = X - F + 1;
    localparam int XW = $clog2(X);
    localparam int YW = $clog2(Y);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        READY = 3'd2,
        SEND  = 3'd3,
        RECV  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   ld_cnt_q, ld_cnt_d;
    logic [XW-1:0]   x_cnt_q, x_cnt_d;
    logic [YW-1:0]   y_cnt_q, y_cnt_d;
    logic [W-1:0]    x_data_q, x_data_d;
    logic            x_valid_q, x_valid_d;
    logic            ld_ready_q, ld_ready_d;
    logic            y_ready_q, y_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    rd_data_q, rd_data_d;

    logic [W-1:0]    xbuf_q [X];
    logic [W-1:0]    rbuf_q [Y];

    logic            start_acc_s;
    logic            ld_acc_s;
    logic            x_xfer_s;
    logic            y_acc_s;
    logic [XW-1:0]   nxt_idx_s;

`ifdef CONV_IO_RELU_CHECK_EN
    logic            relu_err_q, relu_err_d;
`endif

    // Next-state, counter and output-register computation for the controller
    always_comb begin
        state_d     = state_q;
        ld_cnt_d    = ld_cnt_q;
        x_cnt_d     = x_cnt_q;
        y_cnt_d     = y_cnt_q;
        x_data_d    = x_data_q;
        x_valid_d   = x_valid_q;
        // start has priority over a simultaneous load word in READY
        start_acc_s = (state_q == READY) && start;
        ld_acc_s    = ld_valid && ld_ready_q && !start_acc_s;
        x_xfer_s    = x_valid_q && x_ready;
        y_acc_s     = y_valid && y_ready_q;
        nxt_idx_s   = x_cnt_q + XW'(1);

        case (state_q)
            IDLE: begin
                if (ld_acc_s) begin
                    ld_cnt_d = XW'(1);
                    state_d  = LOAD;
                end else begin
                    state_d  = IDLE;
                end
            end
            LOAD: begin
                if (ld_acc_s) begin
                    if (ld_cnt_q == XW'(X - 1)) begin
                        ld_cnt_d = '0;
                        state_d  = READY;
                    end else begin
                        ld_cnt_d = ld_cnt_q + XW'(1);
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            READY: begin
                if (start_acc_s) begin
                    x_cnt_d = '0;
                    state_d = SEND;
                end else if (ld_acc_s) begin
                    ld_cnt_d = XW'(1);
                    state_d  = LOAD;
                end else begin
                    state_d = READY;
                end
            end
            SEND: begin
                // The output register doubles as the prefetch stage: the next
                // word is loaded on the same edge the current one transfers.
                if (!x_valid_q) begin
                    x_valid_d = 1'b1;
                    x_data_d  = xbuf_q[0];
                    x_cnt_d   = '0;
                end else if (x_xfer_s) begin
                    if (x_cnt_q == XW'(X - 1)) begin
                        x_valid_d = 1'b0;
                        x_cnt_d   = '0;
                        state_d   = RECV;
                    end else begin
                        x_cnt_d  = nxt_idx_s;
                        x_data_d = xbuf_q[nxt_idx_s];
                    end
                end else begin
                    x_valid_d = 1'b1;
                end
            end
            RECV: begin
                if (y_acc_s) begin
                    if (y_cnt_q == YW'(Y - 1)) begin
                        y_cnt_d = '0;
                        state_d = DONE;
                    end else begin
                        y_cnt_d = y_cnt_q + YW'(1);
                    end
                end else begin
                    state_d = RECV;
                end
            end
            DONE: begin
                state_d = READY;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ld_ready_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == READY);
        y_ready_d  = (state_d == RECV);
        busy_d     = (state_d == SEND) || (state_d == RECV);
        done_d     = (state_d == DONE);

        if (int'(rd_addr) < Y) begin
            rd_data_d = rbuf_q[rd_addr];
        end else begin
            rd_data_d = '0;
        end
    end

`ifdef CONV_IO_RELU_CHECK_EN
    // Sticky flag for negative result words, cleared when a new run starts
    always_comb begin
        relu_err_d = relu_err_q;
        if (start_acc_s) begin
            relu_err_d = 1'b0;
        end else if (y_acc_s && y_data[W-1]) begin
            relu_err_d = 1'b1;
        end else begin
            relu_err_d = relu_err_q;
        end
    end

    // Relu flag register with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            relu_err_q <= 1'b0;
        end else begin
            relu_err_q <= relu_err_d;
        end
    end

    assign relu_err = relu_err_q;
`endif

    // Controller state and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ld_cnt_q   <= '0;
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            x_data_q   <= '0;
            x_valid_q  <= 1'b0;
            ld_ready_q <= 1'b0;
            y_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            x_cnt_q    <= x_cnt_d;
            y_cnt_q    <= y_cnt_d;
            x_data_q   <= x_data_d;
            x_valid_q  <= x_valid_d;
            ld_ready_q <= ld_ready_d;
            y_ready_q  <= y_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Vector and result buffers; contents survive reset, writes are blocked during it
    always_ff @(posedge clk) begin
        if (reset && ld_acc_s) begin
            xbuf_q[ld_cnt_q] <= ld_data;
        end
        if (reset && y_acc_s) begin
            rbuf_q[y_cnt_q] <= y_data;
        end
    end

    assign ld_ready = ld_ready_q;
    assign x_data   = x_data_q;
    assign x_valid  = x_valid_q;
    assign y_ready  = y_ready_q;
    assign rd_data  = rd_data_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_conv_io_ctrl.sv
// Directed self-checking bench for conv_io_ctrl (default X=32, F=4, W=16).
// The relu_err checks are compiled in when CONV_IO_RELU_CHECK_EN is defined.
module tb_conv_io_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] ld_data;
    logic        ld_valid;
    logic        ld_ready;
    logic        start;
    logic [15:0] x_data;
    logic        x_valid;
    logic        x_ready;
    logic [15:0] y_data;
    logic        y_valid;
    logic        y_ready;
    logic [4:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
`ifdef CONV_IO_RELU_CHECK_EN
    logic        relu_err;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    conv_io_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .ld_data  (ld_data),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .start    (start),
        .x_data   (x_data),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .y_data   (y_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done)
`ifdef CONV_IO_RELU_CHECK_EN
        ,
        .relu_err (relu_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        vec_cnt++;
        if (x_valid !== 1'b0 || y_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            rd_data !== 16'd0 || ld_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_state: xv=%b yr=%b busy=%b done=%b rd=%h ldr=%b, required all 0",
                     x_valid, y_ready, busy, done, rd_data, ld_ready);
        end
        reset = 1'b1;
        tick();
        vec_cnt++;
        if (ld_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_release_ld_ready: got %b, required 1", ld_ready);
        end
    endtask

    task automatic load_vec(input int base);
        vec_cnt++;
        if (ld_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL load_ready_%0d: ld_ready=%b, required 1", base, ld_ready);
        end
        for (int i = 0; i < 32; i++) begin
            ld_data  = 16'(base + i);
            ld_valid = 1'b1;
            tick();
        end
        ld_valid = 1'b0;
        vec_cnt++;
        if (ld_ready !== 1'b1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL load_end_%0d: ld_ready=%b busy=%b, required 1/0", base, ld_ready, busy);
        end
    endtask

    // Full-rate streaming: x_valid rises 2 edges after start, then 32 words back to back
    task automatic test_stream(input int base);
        x_ready = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        vec_cnt++;
        if (busy !== 1'b1 || x_valid !== 1'b0 || ld_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL stream_start: busy=%b xv=%b ldr=%b, required 1/0/0", busy, x_valid, ld_ready);
        end
        for (int i = 0; i < 32; i++) begin
            tick();
            vec_cnt++;
            if (x_valid !== 1'b1 || x_data !== 16'(base + i)) begin
                err_cnt++;
                $display("FAIL stream_word_%0d: xv=%b data=%0d, required 1/%0d", i, x_valid, x_data, base + i);
            end
        end
        tick();
        vec_cnt++;
        if (x_valid !== 1'b0 || y_ready !== 1'b1 || busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL stream_end: xv=%b yr=%b busy=%b, required 0/1/1", x_valid, y_ready, busy);
        end
    endtask

    // Returns 29 words base+k with periodic y_valid gaps; neg_k gets -5; old0>=0 checks read-before-write
    task automatic return_y(input int base, input int neg_k, input int old0);
        int k = 0;
        int cyc = 0;
        int done_seen = 0;
        logic yv;
        logic yr;
        while (k < 29 && cyc < 200) begin
            yv      = ((cyc % 3) != 2);
            y_valid = yv;
            y_data  = (k == neg_k) ? 16'hFFFB : 16'(base + k);
            yr      = y_ready;
            tick();
            cyc++;
            if (yv && yr) begin
                k++;
                if (k == 1 && old0 >= 0) begin
                    vec_cnt++;
                    if (rd_data !== 16'(old0)) begin
                        err_cnt++;
                        $display("FAIL same_cycle_read: got %0d, required old %0d", rd_data, old0);
                    end
                end
            end
            if (done === 1'b1 && k < 29) done_seen++;
        end
        y_valid = 1'b0;
        vec_cnt++;
        if (k != 29) begin
            err_cnt++;
            $display("FAIL y_timeout: accepted %0d, required 29", k);
        end
        vec_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || y_ready !== 1'b0 || done_seen != 0) begin
            err_cnt++;
            $display("FAIL done_pulse: done=%b busy=%b yr=%b early=%0d, required 1/0/0/0",
                     done, busy, y_ready, done_seen);
        end
        tick();
        vec_cnt++;
        if (done !== 1'b0 || ld_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL after_done: done=%b ldr=%b, required 0/1", done, ld_ready);
        end
    endtask

    task automatic test_readback(input int base);
        int addrs [3];
        addrs = '{0, 28, 13};
        for (int i = 0; i < 3; i++) begin
            rd_addr = 5'(addrs[i]);
            tick();
            vec_cnt++;
            if (rd_data !== 16'(base + addrs[i])) begin
                err_cnt++;
                $display("FAIL readback_%0d: got %0d, required %0d", addrs[i], rd_data, base + addrs[i]);
            end
        end
    endtask

    // x_ready pattern 1,0,0,1 repeating: words must hold across stalls, none skipped or repeated
    task automatic test_stall();
        logic pat [4];
        int sent = 0;
        int c = 0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        x_ready = 1'b0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vec_cnt++;
        if (x_valid !== 1'b1 || x_data !== 16'd1) begin
            err_cnt++;
            $display("FAIL stall_first: xv=%b data=%0d, required 1/1", x_valid, x_data);
        end
        while (sent < 32 && c < 300) begin
            x_ready = pat[c % 4];
            tick();
            if (pat[c % 4]) sent++;
            c++;
            vec_cnt++;
            if (sent < 32) begin
                if (x_valid !== 1'b1 || x_data !== 16'(sent + 1)) begin
                    err_cnt++;
                    $display("FAIL stall_word_c%0d: xv=%b data=%0d, required 1/%0d", c, x_valid, x_data, sent + 1);
                end
            end else begin
                if (x_valid !== 1'b0 || y_ready !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL stall_end: xv=%b yr=%b, required 0/1", x_valid, y_ready);
                end
            end
        end
        x_ready = 1'b1;
        vec_cnt++;
        if (sent != 32) begin
            err_cnt++;
            $display("FAIL stall_timeout: sent %0d, required 32", sent);
        end
    endtask

    // start and ld_valid together in READY, then reset at the 10th streamed word
    task automatic test_start_ld_reset();
        x_ready  = 1'b1;
        start    = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 16'hBEEF;
        tick();
        start    = 1'b0;
        ld_valid = 1'b0;
        vec_cnt++;
        if (busy !== 1'b1 || ld_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL start_wins: busy=%b ldr=%b, required 1/0", busy, ld_ready);
        end
        tick();
        vec_cnt++;
        if (x_valid !== 1'b1 || x_data !== 16'd1) begin
            err_cnt++;
            $display("FAIL word0_kept: xv=%b data=%h, required 1/0001", x_valid, x_data);
        end
        for (int i = 0; i < 9; i++) tick();
        vec_cnt++;
        if (x_data !== 16'd10) begin
            err_cnt++;
            $display("FAIL tenth_word: got %0d, required 10", x_data);
        end
        reset = 1'b0;
        tick();
        vec_cnt++;
        if (x_valid !== 1'b0 || busy !== 1'b0 || y_ready !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort: xv=%b busy=%b yr=%b done=%b, required 0", x_valid, busy, y_ready, done);
        end
        reset = 1'b1;
        tick();
        vec_cnt++;
        if (ld_ready !== 1'b1 || x_valid !== 1'b0 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL post_abort: ldr=%b xv=%b busy=%b, required 1/0/0", ld_ready, x_valid, busy);
        end
    endtask

    task automatic test_relu();
`ifdef CONV_IO_RELU_CHECK_EN
        vec_cnt++;
        if (relu_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL relu_clean: got %b, required 0", relu_err);
        end
        test_stream(50);
        return_y(400, 3, -1);
        vec_cnt++;
        if (relu_err !== 1'b1) begin
            err_cnt++;
            $display("FAIL relu_set: got %b, required 1", relu_err);
        end
        test_stream(50);
        vec_cnt++;
        if (relu_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL relu_clear: got %b, required 0", relu_err);
        end
        return_y(500, -1, -1);
`endif
    endtask

    initial begin
        reset    = 1'b1;
        ld_data  = 16'd0;
        ld_valid = 1'b0;
        start    = 1'b0;
        x_ready  = 1'b0;
        y_data   = 16'd0;
        y_valid  = 1'b0;
        rd_addr  = 5'd0;
        tick();
        test_reset();
        load_vec(1);
        test_stream(1);
        return_y(100, -1, -1);
        test_readback(100);
        rd_addr = 5'd0;
        test_stall();
        return_y(200, -1, 100);
        test_readback(200);
        test_start_ld_reset();
        load_vec(50);
        test_stream(50);
        return_y(300, -1, -1);
        test_readback(300);
        test_relu();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
